// File: rtl/jedro_1_decoder.sv
// Registered RV32I decode stage for OP, OP-IMM and LUI with a one-entry
// valid/ready output buffer, backpressure and flush.
module jedro_1_decoder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     instr_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      rd_we_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic                      use_imm_o,
    output logic                      illegal_instr_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [ALU_OP_WIDTH-1:0]   dec_alu_op;
    logic [REG_ADDR_WIDTH-1:0] dec_rs1;
    logic [DATA_WIDTH-1:0]     dec_imm;
    logic                      dec_use_imm;
    logic                      dec_rd_we;
    logic                      dec_illegal;

    logic illegal_q;
    logic capture;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Defaults describe the illegal bundle; each legal encoding overrides it.
    always_comb begin
        dec_alu_op  = '0;
        dec_rs1     = instr_i[19:15];
        dec_imm     = '0;
        dec_use_imm = 1'b0;
        dec_rd_we   = 1'b0;
        dec_illegal = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_alu_op  = ALU_OP_WIDTH'({instr_i[30], funct3});
                    dec_rd_we   = 1'b1;
                    dec_illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) begin
                        dec_alu_op  = ALU_OP_WIDTH'(4'b0001);
                        dec_imm     = DATA_WIDTH'(instr_i[24:20]);
                        dec_use_imm = 1'b1;
                        dec_rd_we   = 1'b1;
                        dec_illegal = 1'b0;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                        dec_alu_op  = ALU_OP_WIDTH'({instr_i[30], 3'b101});
                        dec_imm     = DATA_WIDTH'(instr_i[24:20]);
                        dec_use_imm = 1'b1;
                        dec_rd_we   = 1'b1;
                        dec_illegal = 1'b0;
                    end
                end else begin
                    // bit30 is part of the immediate here, so ADDI never becomes SUB
                    dec_alu_op  = ALU_OP_WIDTH'({1'b0, funct3});
                    dec_imm     = DATA_WIDTH'($signed(instr_i[31:20]));
                    dec_use_imm = 1'b1;
                    dec_rd_we   = 1'b1;
                    dec_illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_rs1     = '0;
                dec_imm     = DATA_WIDTH'({instr_i[31:12], 12'b0});
                dec_use_imm = 1'b1;
                dec_rd_we   = 1'b1;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign instr_ready_o   = !out_valid_o || out_ready_i;
    assign capture         = instr_valid_i && instr_ready_o && !flush_i;
    assign illegal_instr_o = illegal_q && out_valid_o;

    // Bundle fields only move on capture, so they stay stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            alu_op_sel_o <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            imm_o        <= '0;
            use_imm_o    <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (capture) begin
            out_valid_o  <= 1'b1;
            alu_op_sel_o <= dec_alu_op;
            rs1_addr_o   <= dec_rs1;
            rs2_addr_o   <= instr_i[24:20];
            rd_addr_o    <= instr_i[11:7];
            rd_we_o      <= dec_rd_we;
            imm_o        <= dec_imm;
            use_imm_o    <= dec_use_imm;
            illegal_q    <= dec_illegal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Directed-vector bench for jedro_1_decoder: each task drives one scenario and
// compares outputs against hand-decoded expectations.
module tb_jedro_1_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  alu_op_sel_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic [31:0] imm_o;
    logic        use_imm_o;
    logic        illegal_instr_o;

    int vectors = 0;
    int miscompares = 0;

    jedro_1_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .alu_op_sel_o(alu_op_sel_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .imm_o(imm_o),
        .use_imm_o(use_imm_o), .illegal_instr_o(illegal_instr_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle just past it before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; instr_valid_i = 1'b1; instr_i = 32'h00500093;
        flush_i = 1'b0; out_ready_i = 1'b1;
        step(); step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o} !== 55'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got valid=%b op=%h rs1=%0d rs2=%0d rd=%0d we=%b imm=%h ui=%b ill=%b, want all zero",
                     out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o);
        end
        rst_i = 1'b0; instr_valid_i = 1'b0;
        #1;
        vectors++;
        if (instr_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", instr_ready_o); end
        step();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_valid: got %b want 0", out_valid_o); end
    endtask

    task automatic test_addi();
        instr_i = 32'h00500093; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, rd_we_o, illegal_instr_o} !== {1'b1, 4'b0000, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL addi: got valid=%b op=%b rs1=%0d rd=%0d imm=%h ui=%b we=%b ill=%b, want 1 0000 0 1 00000005 1 1 0",
                     out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, rd_we_o, illegal_instr_o);
        end
        // ADDI x1,x0,0x400: bit30 set but must stay ADD
        instr_i = 32'h40000093;
        step();
        vectors++;
        if ({alu_op_sel_o, imm_o, use_imm_o} !== {4'b0000, 32'h00000400, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL addi_bit30: got op=%b imm=%h ui=%b, want 0000 00000400 1", alu_op_sel_o, imm_o, use_imm_o);
        end
        // ADDI x4,x0,-1 checks sign extension
        instr_i = 32'hFFF00213;
        step();
        vectors++;
        if ({alu_op_sel_o, rd_addr_o, imm_o} !== {4'b0000, 5'd4, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("[TB] FAIL addi_signext: got op=%b rd=%0d imm=%h, want 0000 4 ffffffff", alu_op_sel_o, rd_addr_o, imm_o);
        end
        instr_valid_i = 1'b0;
        step();
        vectors++;
        if ({out_valid_o, rd_addr_o} !== {1'b0, 5'd4}) begin
            miscompares++;
            $display("[TB] FAIL consume_hold: got valid=%b rd=%0d, want 0 4", out_valid_o, rd_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        instr_i = 32'h402081B3; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, use_imm_o, rd_we_o, instr_ready_o} !== {1'b1, 4'b1000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL sub: got valid=%b op=%b rs1=%0d rs2=%0d rd=%0d ui=%b we=%b rdy=%b, want 1 1000 1 2 3 0 1 1",
                     out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, use_imm_o, rd_we_o, instr_ready_o);
        end
        instr_i = 32'h40335293;
        step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, rd_we_o} !== {1'b1, 4'b1101, 5'd6, 5'd5, 32'd3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL srai: got valid=%b op=%b rs1=%0d rd=%0d imm=%h ui=%b we=%b, want 1 1101 6 5 00000003 1 1",
                     out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, rd_we_o);
        end
        // OR x0,x1,x2 exercises rd=x0 and a plain funct7=0 register op
        instr_i = 32'h0020E033;
        step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rd_addr_o, rd_we_o, illegal_instr_o} !== {1'b1, 4'b0110, 5'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL or_x0: got valid=%b op=%b rd=%0d we=%b ill=%b, want 1 0110 0 1 0",
                     out_valid_o, alu_op_sel_o, rd_addr_o, rd_we_o, illegal_instr_o);
        end
    endtask

    task automatic test_backpressure();
        instr_i = 32'h123453B7; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0; instr_i = 32'h00A00113;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            vectors++;
            if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, instr_ready_o} !== {1'b1, 4'b0000, 5'd0, 5'd7, 32'h12345000, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL lui_hold[%0d]: got valid=%b op=%b rs1=%0d rd=%0d imm=%h ui=%b rdy=%b, want 1 0000 0 7 12345000 1 0",
                         i, out_valid_o, alu_op_sel_o, rs1_addr_o, rd_addr_o, imm_o, use_imm_o, instr_ready_o);
            end
        end
        step();
        out_ready_i = 1'b1;
        #1;
        vectors++;
        if (instr_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_ready: got %b want 1", instr_ready_o); end
        step();
        vectors++;
        if ({out_valid_o, rd_addr_o, imm_o} !== {1'b1, 5'd2, 32'd10}) begin
            miscompares++;
            $display("[TB] FAIL bp_next: got valid=%b rd=%0d imm=%h, want 1 2 0000000a", out_valid_o, rd_addr_o, imm_o);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h00000000; bad[1] = 32'h4020F1B3; bad[2] = 32'h40209093;
        out_ready_i = 1'b1; instr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_i = bad[i];
            step();
            vectors++;
            if ({out_valid_o, illegal_instr_o, rd_we_o, alu_op_sel_o, use_imm_o, imm_o} !== {1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 32'd0}) begin
                miscompares++;
                $display("[TB] FAIL illegal[%0d]: got valid=%b ill=%b we=%b op=%b ui=%b imm=%h, want 1 1 0 0000 0 00000000",
                         i, out_valid_o, illegal_instr_o, rd_we_o, alu_op_sel_o, use_imm_o, imm_o);
            end
        end
        instr_valid_i = 1'b0;
        step();
        vectors++;
        if ({out_valid_o, illegal_instr_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL illegal_qualified: got valid=%b ill=%b, want 0 0", out_valid_o, illegal_instr_o);
        end
    endtask

    task automatic test_flush();
        instr_i = 32'h00500093; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0; instr_i = 32'h00A00113; flush_i = 1'b1;
        step();
        vectors++;
        if ({out_valid_o, rd_addr_o} !== {1'b0, 5'd1}) begin
            miscompares++;
            $display("[TB] FAIL flush: got valid=%b rd=%0d, want 0 1", out_valid_o, rd_addr_o);
        end
        flush_i = 1'b0; instr_valid_i = 1'b0;
        step();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_dropped: got valid=%b want 0", out_valid_o); end

        instr_i = 32'h123453B7; instr_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0; instr_i = 32'h00A00113;
        step();
        rst_i = 1'b1;
        step();
        vectors++;
        if ({out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o} !== 55'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_hold: got valid=%b op=%h rs1=%0d rs2=%0d rd=%0d we=%b imm=%h ui=%b ill=%b, want all zero",
                     out_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o);
        end
        rst_i = 1'b0; instr_valid_i = 1'b0;
        #1;
        vectors++;
        if (instr_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mid_hold_ready: got %b want 1", instr_ready_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
